// File: rtl/chunked_add_sequencer.sv
// Time-multiplexes one external CHUNK_WIDTH-bit combinational adder over wide operands,
// LSB chunk first, with the carry chained through a register between cycles.
module chunked_add_sequencer #(
  parameter int CHUNK_WIDTH = 8,
  parameter int NUM_CHUNKS  = 4,
  localparam int TOTAL_WIDTH = CHUNK_WIDTH * NUM_CHUNKS
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [TOTAL_WIDTH-1:0] in_a,
  input  logic [TOTAL_WIDTH-1:0] in_b,
  input  logic                   in_cin,
  output logic [CHUNK_WIDTH-1:0] add_a,
  output logic [CHUNK_WIDTH-1:0] add_b,
  output logic                   add_cin,
  input  logic [CHUNK_WIDTH-1:0] add_sum,
  input  logic                   add_cout,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [TOTAL_WIDTH-1:0] out_sum,
  output logic                   out_cout,
  output logic                   busy
);

  localparam int IDX_W = (NUM_CHUNKS > 1) ? $clog2(NUM_CHUNKS) : 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // state is left as a plain named signal so checkers can bind to it directly.
  state_t                 state;
  state_t                 state_next;
  logic [IDX_W-1:0]       chunk_idx;
  logic                   carry_reg;
  logic [TOTAL_WIDTH-1:0] a_reg;
  logic [TOTAL_WIDTH-1:0] b_reg;
  logic                   last_chunk;

  assign last_chunk = (chunk_idx == IDX_W'(NUM_CHUNKS - 1));

  // Handshakes: a transfer happens on a rising edge where valid & ready are both 1.
  // in_ready is high only in IDLE; out_valid is high only in DONE and the result is
  // held unchanged until out_ready is seen, so a stalled consumer never loses data.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    add_a      = '0;
    add_b      = '0;
    add_cin    = 1'b0;
    case (state)
      IDLE: begin
        in_ready = 1'b1;
        if (in_valid) state_next = RUN;
      end
      RUN: begin
        busy    = 1'b1;
        add_cin = carry_reg;
        for (int i = 0; i < NUM_CHUNKS; i++) begin
          if (chunk_idx == IDX_W'(i)) begin
            add_a = a_reg[i*CHUNK_WIDTH +: CHUNK_WIDTH];
            add_b = b_reg[i*CHUNK_WIDTH +: CHUNK_WIDTH];
          end
        end
        if (last_chunk) state_next = DONE;
      end
      DONE: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        if (out_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      chunk_idx <= '0;
      carry_reg <= 1'b0;
      a_reg     <= '0;
      b_reg     <= '0;
      out_sum   <= '0;
      out_cout  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            a_reg     <= in_a;
            b_reg     <= in_b;
            carry_reg <= in_cin;
            chunk_idx <= '0;
          end
        end
        RUN: begin
          for (int i = 0; i < NUM_CHUNKS; i++) begin
            if (chunk_idx == IDX_W'(i)) begin
              out_sum[i*CHUNK_WIDTH +: CHUNK_WIDTH] <= add_sum;
            end
          end
          carry_reg <= add_cout;
          if (last_chunk) begin
            out_cout  <= add_cout;
            chunk_idx <= '0;
          end else begin
            chunk_idx <= chunk_idx + IDX_W'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_chunked_add_sequencer.sv
// Bench for chunked_add_sequencer: default 8x4 instance plus a 4x1 degenerate instance,
// each with a behavioural adder on its add_* ports, checked against wide-arithmetic model.
module tb_chunked_add_sequencer;

  localparam int CW = 8;
  localparam int NC = 4;
  localparam int TW = CW * NC;

  // clock / reset
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // default instance
  logic          in_valid, in_ready, in_cin;
  logic [TW-1:0] in_a, in_b;
  logic [CW-1:0] add_a, add_b, add_sum;
  logic          add_cin, add_cout;
  logic          out_valid, out_ready, out_cout, busy;
  logic [TW-1:0] out_sum;

  assign {add_cout, add_sum} = {1'b0, add_a} + {1'b0, add_b} + {{CW{1'b0}}, add_cin};

  chunked_add_sequencer #(.CHUNK_WIDTH(CW), .NUM_CHUNKS(NC)) u_dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_a(in_a), .in_b(in_b), .in_cin(in_cin),
    .add_a(add_a), .add_b(add_b), .add_cin(add_cin), .add_sum(add_sum), .add_cout(add_cout),
    .out_valid(out_valid), .out_ready(out_ready), .out_sum(out_sum), .out_cout(out_cout),
    .busy(busy)
  );

  // degenerate instance: CHUNK_WIDTH=4, NUM_CHUNKS=1
  logic       in_valid_1, in_ready_1, in_cin_1;
  logic [3:0] in_a_1, in_b_1, add_a_1, add_b_1, add_sum_1, out_sum_1;
  logic       add_cin_1, add_cout_1, out_valid_1, out_ready_1, out_cout_1, busy_1;

  assign {add_cout_1, add_sum_1} = {1'b0, add_a_1} + {1'b0, add_b_1} + {4'd0, add_cin_1};

  chunked_add_sequencer #(.CHUNK_WIDTH(4), .NUM_CHUNKS(1)) u_dut_1 (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid_1), .in_ready(in_ready_1), .in_a(in_a_1), .in_b(in_b_1), .in_cin(in_cin_1),
    .add_a(add_a_1), .add_b(add_b_1), .add_cin(add_cin_1), .add_sum(add_sum_1),
    .add_cout(add_cout_1),
    .out_valid(out_valid_1), .out_ready(out_ready_1), .out_sum(out_sum_1),
    .out_cout(out_cout_1), .busy(busy_1)
  );

  // scoreboard
  logic [TW:0] exp_q[$];
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
  endtask

  // reference: full-width sum with carry-out
  function automatic logic [TW:0] ref_add(input logic [TW-1:0] a, b, input logic cin);
    return {1'b0, a} + {1'b0, b} + {{TW{1'b0}}, cin};
  endfunction

  // reference: carry entering chunk k = carry out of the low k chunks added together
  function automatic logic carry_into(input logic [TW-1:0] a, b, input logic cin, input int k);
    logic [63:0] m;
    logic [63:0] s;
    m = (64'd1 << (CW * k)) - 64'd1;
    s = ({32'd0, a} & m) + ({32'd0, b} & m) + {63'd0, cin};
    return s[CW * k];
  endfunction

  // driver tasks
  task automatic accept(input logic [TW-1:0] a, b, input logic cin);
    int waited = 0;
    in_valid = 1'b1;
    in_a = a;
    in_b = b;
    in_cin = cin;
    while (!in_ready && waited < 20) begin
      tick();
      waited++;
    end
    check("accept_ready", {63'd0, in_ready}, 64'd1);
    exp_q.push_back(ref_add(a, b, cin));
    tick();
    in_valid = 1'b0;
  endtask

  task automatic run_chunks(input logic [TW-1:0] a, b, input logic cin);
    logic [63:0] aa;
    logic [63:0] bb;
    aa = {32'd0, a};
    bb = {32'd0, b};
    for (int k = 0; k < NC; k++) begin
      check("run_busy", {63'd0, busy}, 64'd1);
      check("run_in_ready", {63'd0, in_ready}, 64'd0);
      check("run_out_valid", {63'd0, out_valid}, 64'd0);
      check("add_a", {56'd0, add_a}, (aa >> (CW * k)) & 64'hFF);
      check("add_b", {56'd0, add_b}, (bb >> (CW * k)) & 64'hFF);
      check("add_cin", {63'd0, add_cin}, {63'd0, carry_into(a, b, cin, k)});
      tick();
    end
  endtask

  task automatic finish_op(input int stall);
    logic [TW:0] exp;
    exp = (exp_q.size() > 0) ? exp_q[0] : '0;
    check("done_valid", {63'd0, out_valid}, 64'd1);
    check("done_sum", {32'd0, out_sum}, {32'd0, exp[TW-1:0]});
    check("done_cout", {63'd0, out_cout}, {63'd0, exp[TW]});
    check("done_adder_idle", {47'd0, add_a, add_b, add_cin}, 64'd0);
    check("done_in_ready", {63'd0, in_ready}, 64'd0);
    if (stall > 0) out_ready = 1'b0;
    for (int s = 0; s < stall; s++) begin
      tick();
      check("stall_valid", {63'd0, out_valid}, 64'd1);
      check("stall_sum", {32'd0, out_sum}, {32'd0, exp[TW-1:0]});
      check("stall_cout", {63'd0, out_cout}, {63'd0, exp[TW]});
      check("stall_in_ready", {63'd0, in_ready}, 64'd0);
    end
    out_ready = 1'b1;
    tick();
    if (exp_q.size() > 0) void'(exp_q.pop_front());
    check("post_valid", {63'd0, out_valid}, 64'd0);
    check("post_in_ready", {63'd0, in_ready}, 64'd1);
    check("post_busy", {63'd0, busy}, 64'd0);
  endtask

  task automatic full_op(input logic [TW-1:0] a, b, input logic cin, input int stall);
    accept(a, b, cin);
    run_chunks(a, b, cin);
    finish_op(stall);
  endtask

  initial begin
    logic [TW-1:0] ra, rb;
    rst_n = 1'b0;
    in_valid = 1'b0; in_a = '0; in_b = '0; in_cin = 1'b0; out_ready = 1'b1;
    in_valid_1 = 1'b0; in_a_1 = '0; in_b_1 = '0; in_cin_1 = 1'b0; out_ready_1 = 1'b1;
    repeat (3) tick();
    check("rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("rst_out_valid", {63'd0, out_valid}, 64'd0);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_sum", {31'd0, out_cout, out_sum}, 64'd0);
    check("rst_adder", {47'd0, add_a, add_b, add_cin}, 64'd0);
    rst_n = 1'b1;
    tick();

    // carry ripples through every chunk
    full_op(32'hFFFFFFFF, 32'h00000001, 1'b0, 0);
    // distinct chunk values, carry-in set
    full_op(32'h12345678, 32'h11111111, 1'b1, 0);
    // overflow result held under backpressure
    full_op(32'h80000000, 32'h80000000, 1'b0, 5);

    // requests presented while busy are ignored; the held one is taken in IDLE
    ra = $urandom;
    rb = $urandom;
    accept(ra, rb, 1'b1);
    in_valid = 1'b1; in_a = 32'h1; in_b = 32'h1; in_cin = 1'b0;
    run_chunks(ra, rb, 1'b1);
    finish_op(2);
    check("held_in_valid", {63'd0, in_valid}, 64'd1);
    full_op(32'h1, 32'h1, 1'b0, 0);

    // reset in the middle of RUN discards the operation
    ra = $urandom;
    rb = $urandom;
    accept(ra, rb, 1'b0);
    tick();
    tick();
    check("pre_rst_add_a", {56'd0, add_a}, {56'd0, ra[23:16]});
    rst_n = 1'b0;
    tick();
    rst_n = 1'b1;
    void'(exp_q.pop_back());
    check("mid_rst_valid", {63'd0, out_valid}, 64'd0);
    check("mid_rst_in_ready", {63'd0, in_ready}, 64'd1);
    check("mid_rst_sum", {31'd0, out_cout, out_sum}, 64'd0);
    tick();
    check("mid_rst_still_idle", {63'd0, out_valid}, 64'd0);
    full_op(32'h0000FFFF, 32'h00000001, 1'b0, 0);

    // random operations with random idle gaps and stalls
    for (int n = 0; n < 25; n++) begin
      repeat ($urandom_range(0, 2)) begin
        check("idle_in_ready", {63'd0, in_ready}, 64'd1);
        tick();
      end
      ra = $urandom;
      rb = $urandom;
      full_op(ra, rb, 1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end
    check("sb_empty", 64'(exp_q.size()), 64'd0);

    // degenerate single-chunk instance
    in_valid_1 = 1'b1; in_a_1 = 4'hF; in_b_1 = 4'h1; in_cin_1 = 1'b1;
    check("n1_in_ready", {63'd0, in_ready_1}, 64'd1);
    tick();
    in_valid_1 = 1'b0;
    check("n1_run_add_a", {60'd0, add_a_1}, 64'hF);
    check("n1_run_add_cin", {63'd0, add_cin_1}, 64'd1);
    check("n1_run_valid", {63'd0, out_valid_1}, 64'd0);
    tick();
    check("n1_valid", {63'd0, out_valid_1}, 64'd1);
    check("n1_sum", {60'd0, out_sum_1}, 64'h1);
    check("n1_cout", {63'd0, out_cout_1}, 64'd1);
    tick();
    check("n1_post_valid", {63'd0, out_valid_1}, 64'd0);
    check("n1_post_in_ready", {63'd0, in_ready_1}, 64'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/chunked_add_sequencer.md
Name: chunked_add_sequencer

Overview:
Sequencer that time-multiplexes one external CHUNK_WIDTH-bit combinational adder over wide operands. It accepts a CHUNK_WIDTH*NUM_CHUNKS-bit add request through a valid/ready handshake. It feeds the adder one chunk per cycle, LSB chunk first, chaining the carry through a register. It then presents the assembled sum and carry-out through a second valid/ready handshake. It sits between wide-operand requesters and the existing adder datapath modules.

Parameters:
CHUNK_WIDTH, 8, bit width of the external adder (>=1)
NUM_CHUNKS, 4, number of chunks per operand (>=1); TOTAL_WIDTH = CHUNK_WIDTH*NUM_CHUNKS (derived, not overridable)

Ports:
clk  input  1  single clock, all state updates on rising edge
rst_n  input  1  synchronous active-low reset
in_valid  input  1  request valid
in_ready  output  1  request accepted when in_valid & in_ready at rising edge
in_a  input  TOTAL_WIDTH  operand A
in_b  input  TOTAL_WIDTH  operand B
in_cin  input  1  carry-in to least-significant chunk
add_a  output  CHUNK_WIDTH  chunk of A driven to external adder
add_b  output  CHUNK_WIDTH  chunk of B driven to external adder
add_cin  output  1  carry-in driven to external adder
add_sum  input  CHUNK_WIDTH  external adder sum (combinational from add_a/add_b/add_cin)
add_cout  input  1  external adder carry-out
out_valid  output  1  result valid
out_ready  input  1  result consumed when out_valid & out_ready at rising edge
out_sum  output  TOTAL_WIDTH  assembled sum
out_cout  output  1  carry-out of most-significant chunk
busy  output  1  high in RUN or DONE

Behaviour:
- Clock and reset: one clock `clk`. Reset `rst_n` is synchronous and active-low; it is sampled only on the rising edge of `clk`.
- Reset (rst_n=0 at edge): state=IDLE, chunk_idx=0, carry_reg=0, operand regs=0, out_sum=0, out_cout=0. Reset wins over any simultaneous handshake. A reset during RUN or DONE discards the operation; no out_valid is produced for it.
- FSM states: IDLE, RUN, DONE.
- IDLE: in_ready=1, out_valid=0, busy=0.
  - On in_valid: capture in_a, in_b; carry_reg<=in_cin; chunk_idx<=0; go to RUN.
- RUN: in_ready=0, busy=1.
  - add_a = A[chunk_idx*CHUNK_WIDTH +: CHUNK_WIDTH]; add_b likewise from B; add_cin = carry_reg.
  - Each edge: write add_sum into out_sum at slice chunk_idx; carry_reg<=add_cout; chunk_idx++.
  - When chunk_idx==NUM_CHUNKS-1: out_cout<=add_cout, chunk_idx<=0, go to DONE.
- DONE: out_valid=1, in_ready=0, busy=1.
  - out_sum and out_cout are held stable while out_ready=0 (no limit on stall).
  - On out_ready: go to IDLE.
- Adder drive outside RUN: add_a=0, add_b=0, add_cin=0.
- Latency and throughput:
  - Accept edge = edge 0; out_valid rises after edge NUM_CHUNKS.
  - With out_ready held high: one result per NUM_CHUNKS+2 cycles. in_ready is 1 only in IDLE, so there is no accept in the cycle of the output handshake.
- Boundary conditions:
  - in_valid while busy: ignored; inputs are not sampled.
  - NUM_CHUNKS=1: RUN lasts one cycle; chunk_idx stays 0.
  - Arithmetic is modulo 2^TOTAL_WIDTH; overflow is reported only through out_cout.
  - In IDLE, out_sum/out_cout retain the last result (don't-care to consumers).
- chunk_idx width is max(1, clog2(NUM_CHUNKS)).

Test Plan:
Defaults apply (CHUNK_WIDTH=8, NUM_CHUNKS=4). The bench provides a behavioural adder on the add_* ports.
1. in_a=0xFFFFFFFF, in_b=0x00000001, in_cin=0, out_ready=1 -> out_valid exactly 4 cycles after accept; out_sum=0x00000000, out_cout=1; add_cin=1 on chunks 1..3.
2. in_a=0x12345678, in_b=0x11111111, in_cin=1 -> out_sum=0x2345678A, out_cout=0. Check add_a=0x78,0x56,0x34,0x12 in consecutive RUN cycles.
3. Backpressure: result 0x80000000+0x80000000 with out_ready=0 for 5 cycles -> out_valid stays 1; out_sum=0x00000000 and out_cout=1 stable; in_ready=0. out_ready=1 -> IDLE next cycle, in_ready=1.
4. Busy rejection: present a second request (0x1+0x1) during RUN and DONE with in_valid held -> ignored. Held in_valid is accepted the cycle after returning to IDLE; result=0x00000002.
5. Reset mid-RUN: rst_n=0 for 1 cycle at chunk_idx=2 -> next cycle IDLE, out_valid=0, out_sum=0, out_cout=0. A following request 0x0000FFFF+0x00000001 yields 0x00010000, cout=0.
6. Degenerate NUM_CHUNKS=1, CHUNK_WIDTH=4: 0xF+0x1, cin=1 -> out_sum=0x1, out_cout=1, out_valid 1 cycle after accept.
